ultra_sonic_array: RTL and testbench
====================================

ULTRA_SONIC_ARRAY -- requirements
Module: ultra_sonic_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sensor channels (legal range 1..8).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of each echo-width result (legal range 8..32).
REQ-003 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse length in clk cycles (10 us at 50 MHz).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1900000, maximum wait plus echo duration before a measurement is abandoned.
REQ-005 SHALL have parameter GAP_CYCLES, default 50000, quiet time between consecutive channel firings.
REQ-006 SHALL have port clk, input, 1 bit, 50 MHz system clock; the only clock.
REQ-007 SHALL have port reset_all, input, 1 bit, synchronous active-low reset, sampled on rising clk only.
REQ-008 SHALL have port enable, input, 1 bit, high to run continuous round-robin ranging.
REQ-009 SHALL have port addr, input, 4 bits, register select.
REQ-010 SHALL have port read, input, 1 bit, read strobe, one cycle per access.
REQ-011 SHALL have port read_data, output, 32 bits, registered read result.
REQ-012 SHALL have port echo, input, NUM_CH bits, asynchronous echo lines, one per sensor.
REQ-013 SHALL have port trigger, output, NUM_CH bits, trigger lines, one per sensor, registered.

Function
REQ-014 SHALL pass each echo bit through a 2-flop synchronizer; all echo references below mean the synchronized value (2 cycles of added latency).
REQ-015 SHALL run FSM states IDLE, TRIG, WAIT_ECHO, ON_ECHO, GAP; exactly one channel (cur_ch) is active at a time.
REQ-016 IDLE: trigger all low; enable=1 -> TRIG next cycle; else stay.
REQ-017 TRIG: trigger[cur_ch]=1 for exactly TRIG_CYCLES cycles, other bits 0; then WAIT_ECHO.
REQ-018 WAIT_ECHO: echo[cur_ch]=1 -> ON_ECHO with width counter loaded to 1; timeout counter reaching TIMEOUT_CYCLES -> flag timeout, GAP.
REQ-019 ON_ECHO: width counter increments each cycle echo[cur_ch]=1; echo falls -> latch counter into result[cur_ch], set valid[cur_ch], clear tmo[cur_ch], GAP.
REQ-020 Timeout counter runs from WAIT_ECHO entry through ON_ECHO; reaching TIMEOUT_CYCLES in either state -> set tmo[cur_ch], set valid[cur_ch], result[cur_ch] unchanged, GAP.
REQ-021 Width counter saturates at all-ones of COUNT_WIDTH; it never wraps.
REQ-022 GAP: hold GAP_CYCLES cycles, advance cur_ch (NUM_CH-1 wraps to 0); enable=1 -> TRIG, else IDLE.
REQ-023 Deassertion of enable never aborts a measurement in progress; the current channel finishes through GAP.
REQ-024 Echo on any channel other than cur_ch is ignored.
REQ-025 Register map: addr 0 = status {16'b0, tmo[7:0], valid[7:0]}, unused bits 0; addr 1..NUM_CH = result[addr-1] zero-extended to 32 bits; other addr = 0.
REQ-026 read_data SHALL update one cycle after read=1 and hold its value while read=0.
REQ-027 A read of addr 1..NUM_CH SHALL clear valid[addr-1] and tmo[addr-1]; if a completion for that channel occurs in the same cycle, the set takes priority and the returned data is the pre-update result.
REQ-028 A read of addr 0 SHALL have no side effects.

Reset
REQ-029 With reset_all=0 at a rising clk: state=IDLE, cur_ch=0, trigger=0, read_data=0, all result=0, valid=0, tmo=0, counters=0, synchronizers=0.
REQ-030 Reset mid-measurement SHALL abort it immediately with no partial result latched; trigger drops on the next edge.

Verification (NUM_CH=2, TRIG_CYCLES=4, TIMEOUT_CYCLES=64, GAP_CYCLES=8)
REQ-031 enable=1, echo[0] high for 10 cycles after the trigger -> trigger[0] high exactly 4 cycles; result[0]=10; status read returns 0x0001.
REQ-032 Channel 0 done, then echo[1] high for 20 cycles -> trigger[1] fires after an 8-cycle gap; addr 2 reads 20; status valid[1] clears after that read.
REQ-033 No echo on channel 0 -> 64 cycles after WAIT_ECHO entry, status reads 0x0101; result[0] keeps its previous value.
REQ-034 echo[1] pulsed while cur_ch=0 -> result[1] and valid[1] unchanged.
REQ-035 reset_all=0 during ON_ECHO -> all outputs and registers 0 on the next edge; after release with enable=1, a fresh cycle starts at channel 0.
REQ-036 Read of addr 1 in the same cycle channel 0 completes -> read_data shows the old result; valid[0]=1 afterwards.

Source files
------------

// File: rtl/ultra_sonic_array.sv
// rtl/ultra_sonic_array.sv - round-robin multi-channel ultrasonic ranger with register readout
module ultra_sonic_array #(
  parameter int NUM_CH         = 4,
  parameter int COUNT_WIDTH    = 32,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int GAP_CYCLES     = 50000
) (
  input  logic              clk,
  input  logic              reset_all,
  input  logic              enable,
  input  logic [3:0]        addr,
  input  logic              read,
  output logic [31:0]       read_data,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    ON_ECHO,
    GAP
  } state_t;

  state_t                 state;
  logic [CH_W-1:0]        cur_ch;
  logic [NUM_CH-1:0]      echo_meta;
  logic [NUM_CH-1:0]      echo_sync;
  logic [31:0]            phase_cnt;
  logic [31:0]            tmo_cnt;
  logic [COUNT_WIDTH-1:0] width_cnt;
  logic [COUNT_WIDTH-1:0] result [NUM_CH];
  logic [NUM_CH-1:0]      valid;
  logic [NUM_CH-1:0]      tmo;

  logic [7:0]             valid_ext;
  logic [7:0]             tmo_ext;
  logic [31:0]            rd_mux;
  logic [NUM_CH-1:0]      clr_mask;
  logic                   cur_echo;
  logic                   timeout_hit;
  logic                   trig_done;
  logic                   gap_done;
  logic                   width_full;
  logic [CH_W-1:0]        next_ch;
  logic [NUM_CH-1:0]      cur_onehot;
  logic [NUM_CH-1:0]      next_onehot;

  // Decode the active channel, terminal counts and next-channel selection.
  always_comb begin
    cur_echo    = echo_sync[cur_ch];
    timeout_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    trig_done   = (phase_cnt == 32'(TRIG_CYCLES - 1));
    gap_done    = (phase_cnt == 32'(GAP_CYCLES - 1));
    width_full  = (width_cnt == {COUNT_WIDTH{1'b1}});
    next_ch     = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
    cur_onehot  = NUM_CH'(1) << cur_ch;
    next_onehot = NUM_CH'(1) << next_ch;
  end

  // Register-map read mux and the per-channel flag clears a result read causes.
  always_comb begin
    valid_ext = '0;
    tmo_ext   = '0;
    valid_ext[NUM_CH-1:0] = valid;
    tmo_ext[NUM_CH-1:0]   = tmo;
    rd_mux   = '0;
    clr_mask = '0;
    if (addr == 4'd0) begin
      rd_mux = {16'b0, tmo_ext, valid_ext};
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == 4'(i + 1)) begin
        rd_mux      = 32'(result[i]);
        clr_mask[i] = read;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous echo lines.
  always_ff @(posedge clk) begin
    if (!reset_all) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // Ranging FSM plus register file; a completion set lands after a read clear so it wins.
  always_ff @(posedge clk) begin
    if (!reset_all) begin
      state     <= IDLE;
      cur_ch    <= '0;
      trigger   <= '0;
      read_data <= '0;
      phase_cnt <= '0;
      tmo_cnt   <= '0;
      width_cnt <= '0;
      valid     <= '0;
      tmo       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        result[i] <= '0;
      end
    end else begin
      if (read) begin
        read_data <= rd_mux;
      end
      valid <= valid & ~clr_mask;
      tmo   <= tmo & ~clr_mask;

      case (state)
        IDLE: begin
          trigger <= '0;
          if (enable) begin
            state     <= TRIG;
            phase_cnt <= '0;
            trigger   <= cur_onehot;
          end
        end

        TRIG: begin
          if (trig_done) begin
            state   <= WAIT_ECHO;
            trigger <= '0;
            tmo_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        WAIT_ECHO: begin
          if (timeout_hit) begin
            tmo[cur_ch]   <= 1'b1;
            valid[cur_ch] <= 1'b1;
            state         <= GAP;
            phase_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (cur_echo) begin
              width_cnt <= COUNT_WIDTH'(1);
              state     <= ON_ECHO;
            end
          end
        end

        ON_ECHO: begin
          if (timeout_hit) begin
            tmo[cur_ch]   <= 1'b1;
            valid[cur_ch] <= 1'b1;
            state         <= GAP;
            phase_cnt     <= '0;
          end else if (cur_echo) begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (!width_full) begin
              width_cnt <= width_cnt + COUNT_WIDTH'(1);
            end
          end else begin
            result[cur_ch] <= width_cnt;
            valid[cur_ch]  <= 1'b1;
            tmo[cur_ch]    <= 1'b0;
            state          <= GAP;
            phase_cnt      <= '0;
          end
        end

        GAP: begin
          if (gap_done) begin
            cur_ch    <= next_ch;
            phase_cnt <= '0;
            if (enable) begin
              state   <= TRIG;
              trigger <= next_onehot;
            end else begin
              state <= IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        default: begin
          state   <= IDLE;
          trigger <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultra_sonic_array.sv
// tb/tb_ultra_sonic_array.sv - self-checking bench for ultra_sonic_array
module tb_ultra_sonic_array;

  localparam int NCH  = 2;
  localparam int TRIG = 4;
  localparam int TMO  = 64;
  localparam int GAP  = 8;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            reset_all;
  logic            enable;
  logic [3:0]      addr;
  logic            read;
  logic [31:0]     read_data;
  logic [NCH-1:0]  echo;
  logic [NCH-1:0]  trigger;

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  always #5 clk = ~clk;

  ultra_sonic_array #(
    .NUM_CH(NCH), .COUNT_WIDTH(CW), .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_all(reset_all), .enable(enable), .addr(addr),
    .read(read), .read_data(read_data), .echo(echo), .trigger(trigger)
  );

  // Reference model: one measurement described as a sequence of phases
  logic [NCH-1:0] m_trig = '0;
  logic [31:0]    m_rd = '0;
  logic [CW-1:0]  m_result [NCH];
  logic [NCH-1:0] m_valid = '0;
  logic [NCH-1:0] m_tmo = '0;
  int             m_ch = 0;
  bit             ab = 1'b0;
  bit             s_en = 1'b0;
  logic [NCH-1:0] h1 = '0, h2 = '0, esync = '0;

  task automatic m_tick();
    int a;
    @(posedge clk);
    if (!reset_all) begin
      m_trig = '0; m_rd = '0; m_valid = '0; m_tmo = '0; m_ch = 0;
      h1 = '0; h2 = '0; esync = '0;
      for (int i = 0; i < NCH; i++) m_result[i] = '0;
      ab = 1'b1;
      return;
    end
    s_en  = enable;
    esync = h2;
    h2    = h1;
    h1    = echo;
    if (read) begin
      a = int'(addr);
      if (a == 0) m_rd = {16'b0, 8'(m_tmo), 8'(m_valid)};
      else if (a <= NCH) begin
        m_rd = 32'(m_result[a-1]);
        m_valid[a-1] = 1'b0;
        m_tmo[a-1] = 1'b0;
      end else m_rd = '0;
    end
  endtask

  task automatic m_run();
    logic [CW-1:0] w;
    bit in_echo;
    ab = 1'b0;
    forever begin
      m_tick();
      if (ab) return;
      if (s_en) break;
    end
    forever begin
      m_trig = NCH'(1) << m_ch;
      repeat (TRIG) begin m_tick(); if (ab) return; end
      m_trig = '0;
      in_echo = 1'b0;
      w = '0;
      for (int t = 1; t <= TMO; t++) begin
        m_tick();
        if (ab) return;
        if (t == TMO) begin
          m_tmo[m_ch] = 1'b1; m_valid[m_ch] = 1'b1;
          break;
        end
        if (!in_echo) begin
          if (esync[m_ch]) begin in_echo = 1'b1; w = 1; end
        end else if (esync[m_ch]) begin
          if (w != '1) w = w + 1;
        end else begin
          m_result[m_ch] = w; m_valid[m_ch] = 1'b1; m_tmo[m_ch] = 1'b0;
          break;
        end
      end
      repeat (GAP) begin m_tick(); if (ab) return; end
      m_ch = (m_ch + 1) % NCH;
      if (!s_en) return;
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) m_result[i] = '0;
    forever m_run();
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (check_on) begin
      vectors++;
      if (trigger !== m_trig) begin
        miscompares++;
        $display("FAIL trigger t=%0t got=%b exp=%b", $time, trigger, m_trig);
      end
      vectors++;
      if (read_data !== m_rd) begin
        miscompares++;
        $display("FAIL read_data t=%0t got=%h exp=%h", $time, read_data, m_rd);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_trig(input int ch, input bit level);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (trigger[ch] == level) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_trig ch=%0d got=%b exp=%b (timeout)", ch, trigger[ch], level);
  endtask

  task automatic do_read(input logic [3:0] a);
    read = 1'b1;
    addr = a;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    int cnt;
    reset_all = 1'b0; enable = 1'b0; addr = '0; read = 1'b0; echo = '0;
    @(negedge clk);
    check_on = 1'b1;
    repeat (2) @(negedge clk);
    check_lit("reset_trigger", 32'(trigger), 32'h0);
    check_lit("reset_read_data", read_data, 32'h0);
    reset_all = 1'b1;
    enable = 1'b1;

    // channel 0: trigger width, ignored echo[1], 10-cycle echo
    wait_trig(0, 1'b1);
    cnt = 1;
    for (int i = 0; i < 100 && trigger[0]; i++) begin @(negedge clk); if (trigger[0]) cnt++; end
    check_lit("trig0_width", 32'(cnt), 32'd4);
    echo[1] = 1'b1; repeat (3) @(negedge clk); echo[1] = 1'b0;
    echo[0] = 1'b1; repeat (10) @(negedge clk); echo[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (trigger[1]) break; cnt++; end
    check_lit("gap_to_trig1", 32'(cnt), 32'd10);

    // channel 1: 20-cycle echo, then register reads
    wait_trig(1, 1'b0);
    repeat (2) @(negedge clk);
    echo[1] = 1'b1; repeat (20) @(negedge clk); echo[1] = 1'b0;
    repeat (4) @(negedge clk);
    do_read(4'd0); check_lit("status_both_valid", read_data, 32'h0003);
    do_read(4'd1); check_lit("result0", read_data, 32'd10);
    do_read(4'd2); check_lit("result1", read_data, 32'd20);
    do_read(4'd0); check_lit("status_cleared", read_data, 32'h0000);

    // channel 0 timeout, exact cycle
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    repeat (63) @(negedge clk);
    read = 1'b1; addr = 4'd0;
    @(negedge clk); check_lit("status_before_tmo", read_data, 32'h0000);
    @(negedge clk); check_lit("status_tmo0", read_data, 32'h0101);
    read = 1'b0;
    do_read(4'd1); check_lit("result0_kept", read_data, 32'd10);

    // read of addr 1 coinciding with channel 0 completion
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    repeat (2) @(negedge clk);
    echo[0] = 1'b1; repeat (5) @(negedge clk); echo[0] = 1'b0;
    repeat (2) @(negedge clk);
    do_read(4'd1); check_lit("collide_old_result", read_data, 32'd10);
    do_read(4'd0); check_lit("collide_valid0", read_data & 32'h0101, 32'h0001);
    do_read(4'd1); check_lit("collide_new_result", read_data, 32'd5);

    // reset during ON_ECHO
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    repeat (2) @(negedge clk);
    echo[0] = 1'b1; repeat (4) @(negedge clk);
    reset_all = 1'b0; echo = '0;
    @(negedge clk);
    check_lit("rst_trigger", 32'(trigger), 32'h0);
    check_lit("rst_read_data", read_data, 32'h0);
    reset_all = 1'b1;
    @(negedge clk);
    check_lit("restart_ch0", 32'(trigger), 32'h1);
    do_read(4'd1); check_lit("rst_result0", read_data, 32'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) echo[0] = ~echo[0];
      if ($urandom_range(0, 11) == 0) echo[1] = ~echo[1];
      read = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      reset_all = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
